plot_sink: RTL and testbench

//  Receiving end of the pixel-draw interface driven by the square/score drawers (x, y, colour, plot).

---
 rtl/plot_sink_pkg.sv | 41 ++++
 rtl/plot_fifo.sv | 59 +++++
 rtl/plot_sink.sv | 155 +++++++++++++++
 tb/tb_plot_sink.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plot_sink_pkg.sv
// Shared constants, types and address helpers for the plot_sink framebuffer block.
package plot_sink_pkg;

  localparam int unsigned XRES     = 160;
  localparam int unsigned YRES     = 120;
  localparam int unsigned NPIX     = XRES * YRES;
  localparam int unsigned COORD_W  = 8;
  localparam int unsigned ADDR_W   = 15;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned ENTRY_W  = 2 * COORD_W + COLOUR_W;

  localparam logic [COORD_W-1:0]  X_LIM    = COORD_W'(XRES);
  localparam logic [COORD_W-1:0]  Y_LIM    = COORD_W'(YRES);
  localparam logic [ADDR_W-1:0]   CLR_LAST = ADDR_W'(NPIX - 1);

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0]  x;
    logic [COORD_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } plot_entry_t;

  // y*160 + x without a multiplier
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] px,
                                                 input logic [COORD_W-1:0] py);
    return ({7'd0, py} << 7) + ({7'd0, py} << 5) + {7'd0, px};
  endfunction

  function automatic logic in_range(input logic [COORD_W-1:0] px,
                                    input logic [COORD_W-1:0] py);
    return (px < X_LIM) && (py < Y_LIM);
  endfunction

endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO buffering plot requests; pointers wrap modulo Depth (power of 2).
module plot_fifo #(
  parameter int unsigned Width = 19,
  parameter int unsigned Depth = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [Width-1:0]           wdata,
  output logic [Width-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CntW'(Depth));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push && !flush) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/plot_sink.sv
// Plot FIFO + 160x120x3 framebuffer with scan-out read port and clear engine.
// Optional drop counter output enabled by defining PLOT_SINK_DROPCNT_EN.
module plot_sink
  import plot_sink_pkg::*;
#(
  parameter int unsigned          FIFO_DEPTH = 8,
  parameter logic [COLOUR_W-1:0]  CLR_COLOUR = BLACK
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [COORD_W-1:0]  x,
  input  logic [COORD_W-1:0]  y,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot,
  output logic                ready,
  input  logic                clear,
  input  logic                rd_en,
  input  logic [COORD_W-1:0]  rd_x,
  input  logic [COORD_W-1:0]  rd_y,
  output logic [COLOUR_W-1:0] rd_colour,
  output logic                rd_valid,
  output logic                busy
`ifdef PLOT_SINK_DROPCNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [COLOUR_W-1:0] r_rd_colour;
  logic                r_rd_valid;
  logic [COLOUR_W-1:0] r_fb [NPIX];

  logic                w_in_range;
  logic                w_rd_ok;
  logic                w_push;
  logic                w_pop;
  logic                w_clr_we;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_fifo_count;
  plot_entry_t         w_push_entry;
  plot_entry_t         w_head;
  logic                w_wr_en;
  logic [ADDR_W-1:0]   w_addr;
  logic [COLOUR_W-1:0] w_wr_data;

  assign w_in_range   = in_range(x, y);
  assign w_rd_ok      = in_range(rd_x, rd_y);
  assign w_push       = plot && ready && w_in_range;
  assign w_push_entry = {x, y, colour};

  plot_fifo #(
    .Width (ENTRY_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (clear),
    .push   (w_push),
    .pop    (w_pop),
    .wdata  (w_push_entry),
    .rdata  (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_fifo_count)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= CLEAR;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CLEAR: begin
        if (clear)                                w_state_next = CLEAR;
        else if (w_clr_we && r_clr_addr == CLR_LAST) w_state_next = RUN;
      end
      RUN: begin
        if (clear) w_state_next = CLEAR;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  // Reads own the single RAM port; clear writes and pops only use idle cycles.
  always_comb begin
    ready    = 1'b0;
    busy     = 1'b1;
    w_clr_we = 1'b0;
    w_pop    = 1'b0;
    unique case (r_state)
      CLEAR: begin
        w_clr_we = !rd_en;
      end
      RUN: begin
        ready = !w_full;
        busy  = (w_fifo_count != '0);
        w_pop = !rd_en && !w_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)       r_clr_addr <= '0;
    else if (clear)    r_clr_addr <= '0;
    else if (w_clr_we) r_clr_addr <= (r_clr_addr == CLR_LAST) ? '0 : r_clr_addr + 1'b1;
  end

  assign w_wr_en   = w_clr_we || w_pop;
  assign w_wr_data = w_clr_we ? CLR_COLOUR : w_head.colour;
  assign w_addr    = rd_en    ? pix_addr(rd_x, rd_y)
                   : w_clr_we ? r_clr_addr
                   :            pix_addr(w_head.x, w_head.y);

  always_ff @(posedge clock) begin
    if (w_wr_en) r_fb[w_addr] <= w_wr_data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rd_colour <= BLACK;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_colour <= w_rd_ok ? r_fb[w_addr] : BLACK;
    end
  end

  assign rd_colour = r_rd_colour;
  assign rd_valid  = r_rd_valid;

`ifdef PLOT_SINK_DROPCNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = plot && !(ready && w_in_range);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                              r_drop_cnt <= '0;
    else if (clear)                           r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 1'b1;
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Scoreboard bench for plot_sink: reads queue expected pixels from a framebuffer model.
module tb_plot_sink;
  import plot_sink_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  x = '0, y = '0, rd_x = '0, rd_y = '0;
  logic [2:0]  colour = '0;
  logic        plot = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic        ready, rd_valid, busy;
  logic [2:0]  rd_colour;
`ifdef PLOT_SINK_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clock = ~clock;

  plot_sink dut (
    .clock      (clock),
    .resetn     (resetn),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .ready      (ready),
    .clear      (clear),
    .rd_en      (rd_en),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_colour  (rd_colour),
    .rd_valid   (rd_valid),
    .busy       (busy)
`ifdef PLOT_SINK_DROPCNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         due;
    logic [2:0] col;
    int         px;
    int         py;
  } rd_exp_t;

  rd_exp_t    sb_q[$];
  rd_exp_t    mon_e;
  logic       mon_due;
  logic [2:0] fb [NPIX];
  int         cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // A read sampled on edge k is due at the falling edge that follows it.
  always @(negedge clock) begin
    if (resetn) begin
      mon_due = (sb_q.size() > 0) && (sb_q[0].due == cyc);
      if (mon_due || rd_valid) begin
        check_val("rd_valid", {31'd0, rd_valid}, {31'd0, mon_due});
        if (mon_due) begin
          mon_e = sb_q.pop_front();
          check_val($sformatf("rd_colour(%0d,%0d)", mon_e.px, mon_e.py), {29'd0, rd_colour},
                    {29'd0, mon_e.col});
        end
      end
    end
  end

  function automatic logic [2:0] model_px(input int px, input int py);
    if (px < 160 && py < 120) return fb[py * 160 + px];
    return 3'b000;
  endfunction

  task automatic model_clear();
    foreach (fb[i]) fb[i] = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rd_px(input int px, input int py);
    rd_en = 1'b1;
    rd_x  = 8'(px);
    rd_y  = 8'(py);
    sb_q.push_back('{cyc + 1, model_px(px, py), px, py});
    @(posedge clock);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic plot_px(input int px, input int py, input logic [2:0] c);
    plot   = 1'b1;
    x      = 8'(px);
    y      = 8'(py);
    colour = c;
    if (px < 160 && py < 120) fb[py * 160 + px] = c;
    @(posedge clock);
    #1;
    plot = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp);
    int n = 0;
    while (busy && n < 25000) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_val(tag, n, exp);
  endtask

  initial begin
    model_clear();
    #12;
    check_val("rst_ready", {31'd0, ready}, 0);
    check_val("rst_rd_valid", {31'd0, rd_valid}, 0);
    check_val("rst_busy", {31'd0, busy}, 1);
    check_val("rst_rd_colour", {29'd0, rd_colour}, 0);
    resetn = 1'b1;
    wait_idle("boot_clear_cycles", 19200);
    check_val("ready_after_clear", {31'd0, ready}, 1);
    rd_px(0, 0);
    rd_px(159, 119);
    idle(2);

    plot_px(3, 2, WHITE);
    idle(1);
    rd_px(3, 2);
    idle(2);

    // Continuous reads starve the pop path so the FIFO fills.
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1;
      rd_x  = 8'd0;
      rd_y  = 8'd0;
      sb_q.push_back('{cyc + 1, model_px(0, 0), 0, 0});
      check_val($sformatf("ready_fill%0d", i), {31'd0, ready}, (i < 8) ? 32'd1 : 32'd0);
      plot   = 1'b1;
      x      = 8'(10 + i);
      y      = 8'd10;
      colour = 3'((i % 7) + 1);
      if (i < 8) fb[10 * 160 + 10 + i] = 3'((i % 7) + 1);
      @(posedge clock);
      #1;
    end
    plot  = 1'b0;
    rd_en = 1'b0;
    idle(10);
    for (int i = 0; i < 10; i++) rd_px(10 + i, 10);
    idle(2);
`ifdef PLOT_SINK_DROPCNT_EN
    check_val("drop_overflow", {16'd0, drop_count}, 2);
`endif

    plot_px(40, 6, 3'b101);
    idle(2);
    plot_px(160, 5, WHITE);
    plot_px(5, 120, WHITE);
    idle(3);
    rd_px(0, 5);
    rd_px(0, 6);
    rd_px(200, 5);
    rd_px(40, 6);
    idle(2);
`ifdef PLOT_SINK_DROPCNT_EN
    check_val("drop_oor", {16'd0, drop_count}, 4);
`endif

    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) plot_px(20 + dx, 20 + dy, WHITE);
    idle(3);
    rd_px(21, 21);
    idle(2);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    model_clear();
    check_val("busy_on_clear", {31'd0, busy}, 1);
    wait_idle("clear_cycles", 19200);
`ifdef PLOT_SINK_DROPCNT_EN
    check_val("drop_after_clear", {16'd0, drop_count}, 0);
`endif
    rd_px(21, 21);
    rd_px(20, 20);
    rd_px(3, 2);
    idle(2);

    // Queue 5 pixels behind reads, then reset before any can drain.
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      rd_x  = 8'd0;
      rd_y  = 8'd0;
      sb_q.push_back('{cyc + 1, model_px(0, 0), 0, 0});
      plot   = 1'b1;
      x      = 8'(50 + i);
      y      = 8'd50;
      colour = 3'b110;
      @(posedge clock);
      #1;
    end
    plot  = 1'b0;
    rd_en = 1'b0;
    check_val("busy_drain", {31'd0, busy}, 1);
    check_val("ready_drain", {31'd0, ready}, 1);
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check_val("midrst_ready", {31'd0, ready}, 0);
    check_val("midrst_rd_valid", {31'd0, rd_valid}, 0);
    check_val("midrst_busy", {31'd0, busy}, 1);
    #2;
    resetn = 1'b1;
    model_clear();
    wait_idle("reset_clear_cycles", 19200);
`ifdef PLOT_SINK_DROPCNT_EN
    check_val("drop_after_reset", {16'd0, drop_count}, 0);
`endif
    for (int i = 0; i < 5; i++) rd_px(50 + i, 50);
    idle(3);
    check_val("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
